// File: rtl/systolic_input_skewer_if.sv
// Upstream/PE-facing bundle of the systolic input skewer.
// SKEWER_PERF_CNT_EN adds the BubbleCount signal.
interface systolic_input_skewer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4
);
  logic                       InValid;
  logic                       InReady;
  logic [ROWS*DATA_WIDTH-1:0] InData;
  logic                       InLoad;
  logic                       InLast;
  logic [ROWS*DATA_WIDTH-1:0] OutData;
  logic [ROWS-1:0]            OutEn;
  logic [ROWS-1:0]            OutLoad;
  logic                       Busy;
  logic                       Done;
`ifdef SKEWER_PERF_CNT_EN
  logic [15:0]                BubbleCount;
`endif

  modport master (
    output InValid, InData, InLoad, InLast,
    input  InReady, OutData, OutEn, OutLoad, Busy, Done
`ifdef SKEWER_PERF_CNT_EN
    , input BubbleCount
`endif
  );

  modport slave (
    input  InValid, InData, InLoad, InLast,
    output InReady, OutData, OutEn, OutLoad, Busy, Done
`ifdef SKEWER_PERF_CNT_EN
    , output BubbleCount
`endif
  );
endinterface

// File: rtl/systolic_input_skewer.sv
// Diagonal input skewer for a ROWS x COLS systolic array: lane r delays each slot r+1 cycles.
// Optional macro SKEWER_PERF_CNT_EN adds a saturating STREAM-bubble counter.
module skew_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  act,
  input  logic                  ld,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  en,
  output logic                  load,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DEPTH:1]                 vld_pipe;
  logic [DEPTH:1]                 ld_pipe;
  logic [DEPTH:1][DATA_WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ld_pipe  <= '0;
      dat_pipe <= '0;
    end else if (clr) begin
      vld_pipe <= '0;
      ld_pipe  <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= act;
      ld_pipe[1]  <= ld;
      dat_pipe[1] <= din;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        ld_pipe[i]  <= ld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign en   = vld_pipe[DEPTH];
  assign load = ld_pipe[DEPTH];
  assign dout = dat_pipe[DEPTH];
endmodule

module systolic_input_skewer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                     CLK,
  input  logic                     ASYNC_RST,
  input  logic                     SYNC_RST,
  systolic_input_skewer_if.slave   bus
);
  localparam int CW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FLUSH} state_t;

  state_t                         state;
  logic [CW-1:0]                  cnt;
  logic                           done_q;
  logic                           accept;
  logic                           head_act;
  logic                           head_ld;
  logic [ROWS-1:0][DATA_WIDTH-1:0] head_dat;
  logic [ROWS-1:0][DATA_WIDTH-1:0] lane_dat;
  logic [ROWS-1:0]                lane_en;
  logic [ROWS-1:0]                lane_ld;

  assign bus.InReady = ASYNC_RST & ((state == IDLE) | (state == STREAM));
  assign accept      = bus.InValid & bus.InReady;

  // Bubbles and drain slots are active zero slots so psums keep moving without a stall.
  always_comb begin
    head_act = 1'b0;
    head_ld  = 1'b0;
    head_dat = '0;
    case (state)
      IDLE, STREAM: begin
        head_act = accept | (state == STREAM);
        if (accept) begin
          head_ld  = bus.InLoad;
          head_dat = bus.InData;
        end
      end
      DRAIN:   head_act = 1'b1;
      default: head_act = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (SYNC_RST) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          cnt <= '0;
          if (accept) state <= bus.InLast ? DRAIN : STREAM;
        end
        DRAIN: begin
          if (cnt == CW'(ROWS + COLS - 2)) begin
            state <= FLUSH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FLUSH: begin
          // Last drain slot has left lane ROWS-1 once ROWS cycles have elapsed.
          if (cnt == CW'(ROWS - 1)) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(r + 1)) u_lane (
      .clk   (CLK),
      .rst_n (ASYNC_RST),
      .clr   (SYNC_RST),
      .act   (head_act),
      .ld    (head_ld),
      .din   (head_dat[r]),
      .en    (lane_en[r]),
      .load  (lane_ld[r]),
      .dout  (lane_dat[r])
    );
  end

  assign bus.OutData = lane_dat;
  assign bus.OutEn   = lane_en;
  assign bus.OutLoad = lane_ld;
  assign bus.Busy    = (state != IDLE);
  assign bus.Done    = done_q;

`ifdef SKEWER_PERF_CNT_EN
  logic [15:0] bubble_cnt;

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      bubble_cnt <= '0;
    end else if (SYNC_RST || (state == IDLE && accept)) begin
      bubble_cnt <= '0;
    end else if (state == STREAM && !accept && bubble_cnt != 16'hFFFF) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign bus.BubbleCount = bubble_cnt;
`endif
endmodule

// File: tb/tb_systolic_input_skewer.sv
// Directed bench for systolic_input_skewer (ROWS=COLS=4, DATA_WIDTH=8).
module tb_systolic_input_skewer;
  localparam int DW   = 8;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic CLK = 1'b0;
  logic ASYNC_RST;
  logic SYNC_RST;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic seen_done;

  systolic_input_skewer_if #(.DATA_WIDTH(DW), .ROWS(ROWS)) bus ();

  systolic_input_skewer #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .CLK       (CLK),
    .ASYNC_RST (ASYNC_RST),
    .SYNC_RST  (SYNC_RST),
    .bus       (bus)
  );

  always #5 CLK = ~CLK;

  // Lane 0 = bit 0; cycle c shows head slot from cycle c-1-r.
  logic [3:0]  en2  [1:12] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111,
                               4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [31:0] dat2 [1:12] = '{32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000,
                               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [7:0]  sgn6 [0:3]  = '{8'h80, 8'h7F, 8'hFF, 8'h00};

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic ld, input logic last, input logic [31:0] d);
    bus.InValid = v;
    bus.InLoad  = ld;
    bus.InLast  = last;
    bus.InData  = d;
  endtask

  function automatic logic [7:0] lane(input int r);
    return bus.OutData[r*DW +: DW];
  endfunction

  task automatic wait_done(input int limit);
    while (!bus.Done && cyc < limit) tick();
  endtask

  initial begin
    int k;
    logic [3:0]  e_en, e_ld;
    logic [31:0] e_dat;

    // 1: async reset with InValid high
    ASYNC_RST = 1'b0;
    SYNC_RST  = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hA5A5A5A5);
    tick();
    tick();
    chk("rst_en",    bus.OutEn,   4'b0000);
    chk("rst_load",  bus.OutLoad, 4'b0000);
    chk("rst_data",  bus.OutData, 32'h0);
    chk("rst_ready", bus.InReady, 1'b0);
    chk("rst_busy",  bus.Busy,    1'b0);
    chk("rst_done",  bus.Done,    1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    ASYNC_RST = 1'b1;
    #1;
    chk("rel_ready", bus.InReady, 1'b1);
    tick();

    // 2: single last vector, drain/flush timing
    cyc = 0;
    drive(1'b1, 1'b0, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1});
    chk("t2_ready0", bus.InReady, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t2_ready1", bus.InReady, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      chk("t2_en",   bus.OutEn,   en2[c]);
      chk("t2_data", bus.OutData, dat2[c]);
      chk("t2_load", bus.OutLoad, 4'b0000);
      chk("t2_busy", bus.Busy,    (c < 12));
      chk("t2_done", bus.Done,    (c == 12));
      if (c < 12) tick();
    end

    // 3: starts in the Done cycle; two weight vectors then three activations
    cyc = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c <= 4) begin
        drive(1'b1, (c < 2), (c == 4), {4{8'(c + 1)}});
        chk("t3_ready", bus.InReady, 1'b1);
      end else begin
        drive(1'b0, 1'b0, 1'b0, 32'h0);
      end
      if (c >= 1) begin
        e_en = '0; e_ld = '0; e_dat = '0;
        for (int r = 0; r < ROWS; r++) begin
          k = c - 1 - r;
          e_en[r] = (k >= 0 && k <= 11);
          e_ld[r] = (k == 0 || k == 1);
          if (k >= 0 && k <= 4) e_dat[r*8 +: 8] = 8'(k + 1);
        end
        chk("t3_en",   bus.OutEn,   e_en);
        chk("t3_load", bus.OutLoad, e_ld);
        chk("t3_data", bus.OutData, e_dat);
      end
      tick();
    end
    wait_done(40);
    chk("t3_done_cyc", cyc, 16);
    chk("t3_busy",     bus.Busy, 1'b0);
    tick();
    chk("t3_done_pulse", bus.Done, 1'b0);

    // 4: bubble between two activations
    cyc = 0;
    drive(1'b1, 1'b0, 1'b0, {4{8'h11}});
    tick();
    drive(1'b0, 1'b1, 1'b1, {4{8'hEE}});
    tick();
    drive(1'b1, 1'b0, 1'b1, {4{8'h22}});
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 3; c <= 6; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (c == 1 + r) chk("t4_a", lane(r), 8'h11);
        if (c == 2 + r) begin
          chk("t4_bub_en",  bus.OutEn[r], 1'b1);
          chk("t4_bub_dat", lane(r),      8'h00);
          chk("t4_bub_ld",  bus.OutLoad[r], 1'b0);
        end
        if (c == 3 + r) chk("t4_b", lane(r), 8'h22);
      end
`ifdef SKEWER_PERF_CNT_EN
      if (c == 3) chk("t4_bubcnt", bus.BubbleCount, 16'd1);
`endif
      tick();
    end
    wait_done(40);
    chk("t4_done_cyc", cyc, 14);
    tick();

    // 5: synchronous clear during DRAIN
    cyc = 0;
    drive(1'b1, 1'b0, 1'b1, {4{8'h55}});
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("t5_busy_pre", bus.Busy, 1'b1);
    SYNC_RST = 1'b1;
    tick();
    SYNC_RST = 1'b0;
    chk("t5_en",    bus.OutEn,   4'b0000);
    chk("t5_load",  bus.OutLoad, 4'b0000);
    chk("t5_data",  bus.OutData, 32'h0);
    chk("t5_busy",  bus.Busy,    1'b0);
    chk("t5_ready", bus.InReady, 1'b1);
    seen_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      seen_done |= bus.Done;
      tick();
    end
    chk("t5_no_done", seen_done, 1'b0);

    // 6: signed extremes pass through unchanged
    cyc = 0;
    drive(1'b1, 1'b0, 1'b1, {8'h00, 8'hFF, 8'h7F, 8'h80});
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      chk("t6_dat", lane(c - 1), sgn6[c - 1]);
      chk("t6_en",  bus.OutEn[c - 1], 1'b1);
      tick();
    end
    wait_done(40);
    chk("t6_done_cyc", cyc, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_input_skewer.md
Name: systolic_input_skewer

Overview:
- Sits directly upstream of the PE array and drives the `Input`, `EN` and `LOAD` pins of the left-most PE of each row.
- Accepts one ROWS-wide vector per cycle (a weight vector or an activation vector) over a valid/ready handshake.
- Applies the diagonal skew the systolic array needs: row r sees each vector r cycles after row 0.
- After the last vector it injects zero slots so that every partial sum drains out of the bottom of the array, then pulses Done.

Parameters:
- DATA_WIDTH, 8, width of one element (matches the PE DATA_WIDTH).
- ROWS, 4, number of PE rows = elements per vector = number of skew lanes.
- COLS, 4, number of PE columns; sets the drain length.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- ASYNC_RST  in  1  asynchronous active-low reset.
- SYNC_RST  in  1  synchronous active-high clear.
- InValid  in  1  a vector is offered.
- InReady  out  1  the skewer can accept a vector this cycle.
- InData  in  ROWS*DATA_WIDTH  signed elements; row r is bits [r*DATA_WIDTH +: DATA_WIDTH].
- InLoad  in  1  the offered vector is weights (drives LOAD) rather than activations.
- InLast  in  1  the offered vector is the last of the job.
- OutData  out  ROWS*DATA_WIDTH  skewed data; lane r goes to the `Input` of row r, column 0.
- OutEn  out  ROWS  per-row `EN` for the PEs of row r.
- OutLoad  out  ROWS  per-row `LOAD` for the PEs of row r.
- Busy  out  1  state is not IDLE.
- Done  out  1  one-cycle pulse when the job is fully flushed.

Behaviour:
- Reset: ASYNC_RST low or SYNC_RST high clears all pipeline registers and counters and forces state IDLE.
  - Outputs after reset: OutData=0, OutEn=0, OutLoad=0, Busy=0, Done=0.
  - InReady=0 while ASYNC_RST is low; otherwise combinational from the state, so it is 1 in IDLE (including the cycle SYNC_RST is high).
  - A reset mid-job aborts the job with no Done pulse.
- Slot: each cycle the head of the pipe takes one slot {active, load, data[ROWS]}.
  - Accept (InValid & InReady): slot = {1, InLoad, InData}.
  - STREAM cycle with no accept (bubble): slot = {1, 0, zeros}.
  - DRAIN slot: {1, 0, zeros}.
  - IDLE and FLUSH slot: {0, 0, zeros}.
- Skew: lane r outputs the slot from r+1 cycles earlier, via a per-lane delay line of depth r+1, all stages registered.
  - Lane 0 latency = 1 cycle; lane ROWS-1 latency = ROWS cycles.
  - OutEn[r] = active bit of the delayed slot.
  - OutLoad[r] = load bit of the delayed slot.
  - OutData lane r = data element r of the delayed slot.
- Bubbles and drain slots feed zero activations with EN=1. The PE computes 0*w+PsumIn, so psums pass through unchanged; no stall is ever needed.
- FSM states and transitions:
  - IDLE: InReady=1. An accept goes to STREAM, or to DRAIN if InLast is set on that vector.
  - STREAM: InReady=1. An accept with InLast goes to DRAIN; otherwise stay.
  - DRAIN: InReady=0. A counter injects ROWS+COLS-1 drain slots, then goes to FLUSH.
  - FLUSH: InReady=0. Waits ROWS cycles so the last slot leaves lane ROWS-1, then pulses Done for one cycle and returns to IDLE. Done coincides with the first IDLE cycle; an accept in that cycle starts a new job.
- A weight vector and an activation vector are never merged into one slot. Switching InLoad between consecutive vectors is legal; each lane sees the switch at its own skewed time.
- InValid is ignored while InReady=0. InData, InLoad and InLast are don't-care when InValid=0.
- Counter widths use $clog2 of ROWS+COLS and must not wrap.

Optional Feature:
- Macro: SKEWER_PERF_CNT_EN.
- Defined: adds output BubbleCount, 16 bits.
  - Increments on every STREAM bubble and saturates at 16'hFFFF.
  - Cleared by either reset and on the IDLE-to-STREAM/DRAIN transition.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
All scenarios use ROWS=4, COLS=4, DATA_WIDTH=8.
1. Reset: hold ASYNC_RST low two cycles with InValid=1 -> OutEn=0000, OutLoad=0000, OutData=0, InReady=0, Busy=0. Release with SYNC_RST=0 -> InReady=1.
2. Single vector at cycle 0: InData={4,3,2,1} (lane0=1), InLoad=0, InLast=1 -> lane r shows value r+1 with OutEn[r]=1 at cycle 1+r. InReady=0 from cycle 1. Drain slots at cycles 1..7. Done pulses at cycle 12 and Busy falls the same cycle.
3. Weight load then compute, back-to-back: two InLoad=1 vectors, then three InLoad=0 vectors (last one has InLast) -> OutLoad[r] high exactly at cycles 1+r and 2+r; OutLoad[3] high at cycles 4-5; activations follow with no gap.
4. Bubble: accept at cycle 0, InValid=0 at cycle 1, accept with InLast at cycle 2 -> every lane r shows OutEn=1 with data 0 at cycle 2+r. With SKEWER_PERF_CNT_EN, BubbleCount=1.
5. Mid-job reset: SYNC_RST pulsed during DRAIN -> all outputs 0 next cycle, no Done pulse, InReady=1.
6. Signed extremes: InData lanes {-128,127,-1,0} -> values appear unchanged on the skewed lanes at the latencies above.
